mux_scan_module: RTL

Parametrised N-channel, WIDTH-bit registered multiplexer with active-low chip select. Two modes: manual selection by address, or automatic round-robin scanning with a programmable dwell per channel. It sits between multi-source data buses and a single shared consumer, such as a display or UART, that must be time-shared across sources.

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/mux_scan_next.sv | 27 ++
 rtl/mux_scan_module.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning multiplexer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Circular next-enabled-channel finder: searches ptr+1, ptr+2, ... and finally ptr itself.
module mux_scan_next #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS-1:0] en,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    next_idx,
    output logic                found,
    output logic                wrap
);

    // Walk offsets from farthest to nearest so the nearest enabled channel wins.
    always_comb begin
        logic [SEL_W-1:0] cand;
        cand     = '0;
        next_idx = ptr;
        for (int off = CHANNELS; off >= 1; off--) begin
            cand = SEL_W'((int'(ptr) + off) % CHANNELS);
            if (en[cand]) next_idx = cand;
        end
    end

    assign found = |en;
    assign wrap  = found && (next_idx <= ptr);

endmodule

// File: rtl/mux_scan_module.sv
// N-channel registered mux with manual addressing or round-robin scan.
// Define MUX_SCAN_MASK_EN to add the per-channel EN port and masked scanning.
module mux_scan_module
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 4,
    localparam int SEL_W   = clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CSn,
    input  logic                      MODE,
    input  logic [SEL_W-1:0]          A,
    input  logic [WIDTH*CHANNELS-1:0] D,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       EN,
`endif
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          CH,
    output logic                      VALID,
    output logic                      WRAP
);

    localparam int CNT_W = (DWELL > 1) ? clog2(DWELL) : 1;

    state_t             state, state_next;
    logic [SEL_W-1:0]   ptr, ptr_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_now;
    logic               wrap_pend, wrap_pend_d;
    logic [WIDTH-1:0]   y_d;
    logic [SEL_W-1:0]   ch_d;
    logic               valid_d, wrap_d;

    logic [WIDTH-1:0]   chan [CHANNELS];
    logic [CHANNELS-1:0] en_mask;
    logic [SEL_W-1:0]   first_ch, cur_ch, adv_ch;
    logic               adv_wrap, any_en, entering, a_in_range;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chan[k] = D[k*WIDTH +: WIDTH];
    end

`ifdef MUX_SCAN_MASK_EN
    assign en_mask = EN;

    always_comb begin
        first_ch = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (en_mask[k]) first_ch = SEL_W'(k);
        end
    end

    mux_scan_next #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_next (
        .en       (en_mask),
        .ptr      (cur_ch),
        .next_idx (adv_ch),
        .found    (any_en),
        .wrap     (adv_wrap)
    );
`else
    assign en_mask  = '1;
    assign first_ch = '0;
    assign any_en   = 1'b1;
    assign adv_wrap = (cur_ch == SEL_W'(CHANNELS - 1));
    assign adv_ch   = adv_wrap ? '0 : cur_ch + 1'b1;
`endif

    // A fresh entry into scan always starts a full dwell on the first channel.
    assign entering   = (state != ST_SCAN);
    assign cur_ch     = entering ? first_ch : ptr;
    assign cnt_now    = entering ? '0 : cnt;
    assign a_in_range = (int'(A) < CHANNELS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        if (!CSn) begin
            if (MODE == MODE_MANUAL) state_next = ST_MAN;
            else if (MODE == MODE_SCAN) state_next = ST_SCAN;
        end
    end

    // Next values for the registered outputs; idle and manual leave ptr/cnt cleared.
    always_comb begin
        y_d         = '0;
        ch_d        = '0;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        ptr_d       = '0;
        cnt_d       = '0;
        wrap_pend_d = 1'b0;
        case (state_next)
            ST_MAN: begin
                ch_d = A;
                if (a_in_range && en_mask[A]) begin
                    y_d     = chan[A];
                    valid_d = 1'b1;
                end
            end
            ST_SCAN: begin
                ch_d  = cur_ch;
                ptr_d = ptr;
                cnt_d = cnt;
                if (any_en) begin
                    if (en_mask[cur_ch]) begin
                        y_d     = chan[cur_ch];
                        valid_d = 1'b1;
                    end
                    wrap_d = !entering && wrap_pend;
                    if (cnt_now == CNT_W'(DWELL - 1)) begin
                        cnt_d       = '0;
                        ptr_d       = adv_ch;
                        wrap_pend_d = adv_wrap;
                    end else begin
                        cnt_d = cnt_now + 1'b1;
                        ptr_d = cur_ch;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Y         <= '0;
            CH        <= '0;
            VALID     <= 1'b0;
            WRAP      <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            wrap_pend <= 1'b0;
        end else begin
            Y         <= y_d;
            CH        <= ch_d;
            VALID     <= valid_d;
            WRAP      <= wrap_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            wrap_pend <= wrap_pend_d;
        end
    end

endmodule
